serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit full-adder cell.
- Adds or subtracts two WIDTH-bit operands bit-serially, LSB first, using one full-adder slice and a registered carry.
- Uses a start/busy/done handshake and produces carry-out and signed-overflow flags.
- Serves as the area-minimal arithmetic unit for datapaths where latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only when not busy.
- sub  input  1  operation select: 0 = add, 1 = subtract (a - b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- c_in  input  1  carry-in for add; ignored when sub = 1; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when a result becomes valid.
- sum  output  WIDTH  result register.
- c_out  output  1  carry out of the MSB; in subtract mode, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (synchronous, active-high)
  - State goes to IDLE; bit counter, operand shift registers and carry flop clear to 0.
  - Outputs: busy = 0, done = 0, sum = 0, c_out = 0, overflow = 0.
  - Reset has priority over all other inputs.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced for it.
- States
  - IDLE: waiting for start.
  - RUN: processing one bit per cycle.
  - DONE: single cycle in which done = 1.
- Accepting an operation
  - A start at rising edge k is accepted in IDLE or DONE.
  - On acceptance, latch a into the A shift register.
  - Latch B as b when sub = 0, or ~b when sub = 1.
  - Set the carry flop to c_in when sub = 0, or to 1 when sub = 1.
  - Clear the bit counter and go to RUN; busy = 1 from the cycle after edge k.
- RUN
  - At each edge k+1+i, for i = 0..WIDTH-1, compute bit i: s_i = A0 ^ B0 ^ carry.
  - The carry flop takes the majority of (A0, B0, carry).
  - Shift A and B right by one; shift s_i into the MSB of the internal result shift register.
  - Before computing the final bit (i = WIDTH-1), record the incoming carry as carry-into-MSB.
- Completion
  - At edge k+WIDTH the state goes to DONE.
  - sum, c_out and overflow update at that edge.
  - For the cycle between edges k+WIDTH and k+WIDTH+1: done = 1 and busy = 0.
- Latency: exactly WIDTH cycles from the accepting edge to done, for every WIDTH.
  - WIDTH = 1 gives done one cycle after start.
- Output stability
  - sum, c_out and overflow change only at completion or reset.
  - They hold their previous result throughout RUN and IDLE. Partial sums are never visible.
- Exit from DONE
  - With start = 0, go to IDLE at the next edge.
  - With start = 1, accept a new operation at that edge (back-to-back operation, no idle gap); done drops to 0.
- start while in RUN is ignored; operands and mode are unaffected.
- Result arithmetic: the result equals (a + b + c_in) mod 2^WIDTH, or (a - b) mod 2^WIDTH.
- Changes on a, b, sub or c_in after the accepting edge have no effect.

Test Plan:
- WIDTH=8, add a=8'h5A, b=8'h3C, c_in=0 -> done exactly 8 cycles after start; sum=8'h96, c_out=0, overflow=1.
- Add a=8'hFF, b=8'h00, c_in=1 -> sum=8'h00, c_out=1, overflow=0. Add a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1, overflow=0.
- Subtract a=8'h10, b=8'h20 -> sum=8'hF0, c_out=0, overflow=0. Subtract a=8'h80, b=8'h01 -> sum=8'h7F, c_out=1, overflow=1.
- Back-to-back and busy behaviour:
  - Hold start high through DONE -> second operation accepted with no idle cycle.
  - Pulse start with new operands mid-RUN -> pulse ignored; first result unchanged.
  - sum holds the prior value until the new done.
- Reset mid-operation: assert reset 3 cycles into RUN -> next cycle busy=0, done=0, sum=0, c_out=0, overflow=0; no done pulse follows. A subsequent start completes normally.
- WIDTH=1 instance:
  - Add a=1, b=1, c_in=1 -> done 1 cycle after start; sum=1, c_out=1, overflow=0.
  - Subtract a=0, b=1 -> sum=1, c_out=0, overflow=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial add/subtract of two WIDTH-bit operands, LSB first, one full-adder slice.
// Latency: WIDTH cycles from the accepting edge to the done pulse.
// Backpressure: start is accepted only in IDLE or DONE; start during RUN is ignored.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH = 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // The final bit goes straight into sum, so only WIDTH-1 result bits are staged.
    localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [RW-1:0]    res_sr;
    logic             carry;

    logic             bit_s;
    logic             bit_c;
    logic [RW-1:0]    res_shift;
    logic [WIDTH-1:0] res_next;

    // Single full-adder slice working on the current LSBs and the registered carry.
    always_comb begin
        bit_s = a_sr[0] ^ b_sr[0] ^ carry;
        bit_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    // Result staging: each new bit enters at the top of the staging register, so after
    // WIDTH-1 shifts bit 0 sits at the LSB and the last bit completes the word on top.
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_shift = res_sr;
            assign res_next  = bit_s;
        end else if (WIDTH == 2) begin : g_w2
            assign res_shift = bit_s;
            assign res_next  = {bit_s, res_sr};
        end else begin : g_wn
            assign res_shift = {bit_s, res_sr[RW-1:1]};
            assign res_next  = {bit_s, res_sr};
        end
    endgenerate

    // Control FSM and datapath; visible outputs only change at completion or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1, so invert B and force the carry.
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : c_in;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= bit_c;
                    res_sr <= res_shift;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB at this point.
                        sum      <= res_next;
                        c_out    <= bit_c;
                        overflow <= carry ^ bit_c;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
